tl_sensor_cond: RTL and testbench

//  Conditions the two raw street car-detector inputs into the Ta/Tb traffic-present

---
 rtl/tl_sensor_cond.sv | 148 ++++++++++++++
 tb/tb_tl_sensor_cond.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tl_sensor_cond.sv
// Street car-detector conditioning: per-lane 2-flop sync, debounce, presence hold
// extension and a stuck-sensor monitor that forces "no traffic" and flags a fault.
module tl_sensor_cond #(
    parameter int DB_CYCLES    = 4,
    parameter int HOLD_CYCLES  = 3,
    parameter int STUCK_CYCLES = 64,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic Ta,
    output logic Tb,
    output logic fault_a,
    output logic fault_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } lane_state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Lane 0 is street A, lane 1 is street B; the lanes share nothing but the clock.
    logic [1:0] raw;
    logic [1:0] present;
    logic [1:0] stuck;

    assign raw     = {raw_b, raw_a};
    assign Ta      = present[0];
    assign Tb      = present[1];
    assign fault_a = stuck[0];
    assign fault_b = stuck[1];

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic             s1;
        logic             s2;
        logic             db;
        logic [CNT_W-1:0] db_cnt;

        lane_state_t      state;
        lane_state_t      state_nxt;
        logic [CNT_W-1:0] hold_cnt;
        logic [CNT_W-1:0] hold_nxt;
        logic [CNT_W-1:0] stuck_cnt;
        logic [CNT_W-1:0] stuck_nxt;
        logic             t_q;
        logic             t_nxt;
        logic             f_q;
        logic             f_nxt;

        // s1 may go metastable; only s2 is allowed to feed any decision.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1     <= 1'b0;
                s2     <= 1'b0;
                db     <= 1'b0;
                db_cnt <= '0;
            end else begin
                // NOTE: non-blocking so s2 takes the old s1; blocking here would collapse the synchronizer.
                s1 <= raw[i];
                s2 <= s1;
                if (s2 == db) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db     <= s2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= IDLE;
                hold_cnt  <= '0;
                stuck_cnt <= '0;
                t_q       <= 1'b0;
                f_q       <= 1'b0;
            end else begin
                state     <= state_nxt;
                hold_cnt  <= hold_nxt;
                stuck_cnt <= stuck_nxt;
                t_q       <= t_nxt;
                f_q       <= f_nxt;
            end
        end

        always_comb begin
            // NOTE: every output defaults first so no path through the case infers a latch.
            state_nxt = state;
            hold_nxt  = hold_cnt;
            stuck_nxt = stuck_cnt;
            case (state)
                IDLE: begin
                    if (db) begin
                        state_nxt = BUSY;
                        stuck_nxt = '0;
                    end
                end
                BUSY: begin
                    if (!db) begin
                        state_nxt = HOLD;
                        hold_nxt  = HOLD_LAST;
                    end else if (stuck_cnt == STUCK_LAST) begin
                        state_nxt = FAULT;
                    end else begin
                        stuck_nxt = stuck_cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    // Re-arrival is tested before expiry so a returning car keeps Tx high.
                    if (db) begin
                        state_nxt = BUSY;
                        stuck_nxt = '0;
                    end else if (hold_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        hold_nxt = hold_cnt - CNT_ONE;
                    end
                end
                FAULT: begin
                    if (!db) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            // Outputs decode the next state so they land in flops alongside it.
            t_nxt = (state_nxt == BUSY) || (state_nxt == HOLD);
            f_nxt = (state_nxt == FAULT);
        end

        assign present[i] = t_q;
        assign stuck[i]   = f_q;
    end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Directed bench for tl_sensor_cond: table-driven phases plus hand-written
// sequences for stuck detection, hold re-arrival and asynchronous reset.
module tb_tl_sensor_cond;

    logic clk = 1'b0;
    logic reset;
    logic raw_a;
    logic raw_b;
    logic ta;
    logic tb;
    logic fault_a;
    logic fault_b;
    logic raw_a_h;
    logic raw_b_h;
    logic ta_h;
    logic tb_h;
    logic fault_a_h;
    logic fault_b_h;
    logic [3:0] outs;
    logic [3:0] outs_h;
    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    tl_sensor_cond u_dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .Ta      (ta),
        .Tb      (tb),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    // Longer hold so a re-arrival can land inside HOLD exactly at expiry.
    tl_sensor_cond #(.HOLD_CYCLES(4)) u_dut_h (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a_h),
        .raw_b   (raw_b_h),
        .Ta      (ta_h),
        .Tb      (tb_h),
        .fault_a (fault_a_h),
        .fault_b (fault_b_h)
    );

    assign outs   = {ta, tb, fault_a, fault_b};
    assign outs_h = {ta_h, tb_h, fault_a_h, fault_b_h};

    typedef struct {
        logic       ra;
        logic       rb;
        int         n;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got {Ta,Tb,fa,fb}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e;
        int c;

        // {raw_a, raw_b, ticks, expected outputs on every tick of the phase}
        vecs[0]  = '{1'b0, 1'b0, 3,  4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 6,  4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 1,  4'b1000};
        vecs[3]  = '{1'b1, 1'b1, 3,  4'b1000};
        vecs[4]  = '{1'b1, 1'b0, 10, 4'b1000};
        vecs[5]  = '{1'b0, 1'b0, 9,  4'b1000};
        vecs[6]  = '{1'b0, 1'b0, 1,  4'b0000};
        vecs[7]  = '{1'b0, 1'b1, 4,  4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 2,  4'b0000};
        vecs[9]  = '{1'b0, 1'b0, 7,  4'b0100};
        vecs[10] = '{1'b0, 1'b0, 1,  4'b0000};
        vecs[11] = '{1'b1, 1'b1, 6,  4'b0000};
        vecs[12] = '{1'b1, 1'b1, 5,  4'b1100};
        vecs[13] = '{1'b0, 1'b0, 9,  4'b1100};
        vecs[14] = '{1'b0, 1'b0, 2,  4'b0000};

        // Test 1: reset low for 20 ns.
        reset   = 1'b0;
        raw_a   = 1'b0;
        raw_b   = 1'b0;
        raw_a_h = 1'b0;
        raw_b_h = 1'b0;
        #1;
        check("t1_reset_early", outs, 4'b0000);
        check("t1_reset_early_h", outs_h, 4'b0000);
        #19;
        check("t1_reset_late", outs, 4'b0000);
        #2;
        reset = 1'b1;
        tick();

        // Tests 2-4 and simultaneous A/B: phases from the table.
        c = 0;
        for (int v = 0; v < 15; v++) begin
            raw_a = vecs[v].ra;
            raw_b = vecs[v].rb;
            for (int j = 0; j < vecs[v].n; j++) begin
                tick();
                c++;
                check($sformatf("vec%0d_c%0d", v, c), outs, vecs[v].exp);
            end
        end

        // Test 5: stuck sensor on A, then release.
        raw_a = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            e = {(i >= 7 && i < 71), 1'b0, (i >= 71), 1'b0};
            check($sformatf("stuck_i%0d", i), outs, e);
        end
        raw_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            e = {1'b0, 1'b0, (i < 7), 1'b0};
            check($sformatf("stuck_clear_i%0d", i), outs, e);
        end

        // Re-arrival at the last HOLD cycle keeps Ta_h high; final release holds 4 cycles.
        raw_a_h = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            e = {(i >= 7 && i < 41), 3'b000};
            check($sformatf("rearrive_i%0d", i), outs_h, e);
            if (i == 12) raw_a_h = 1'b0;
            if (i == 16) raw_a_h = 1'b1;
            if (i == 30) raw_a_h = 1'b0;
        end

        // Test 6: A goes stuck while B is later put into HOLD, then async reset.
        raw_a = 1'b1;
        for (int i = 1; i <= 78; i++) begin
            tick();
            e = {(i >= 7 && i < 71), (i >= 17 && i < 80), (i >= 71), 1'b0};
            check($sformatf("t6_i%0d", i), outs, e);
            if (i == 10) raw_b = 1'b1;
            if (i == 70) raw_b = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_reset", outs, 4'b0000);
        raw_a = 1'b0;
        raw_b = 1'b0;
        #10;
        check("t6_reset_held", outs, 4'b0000);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t6_post_reset_i%0d", i), outs, 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
